// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and status bundle for the modulo up/down counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             E;
  logic             F;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             sat;
  logic [WIDTH-1:0] y_out;
  logic             tc;
  logic             sat_hit;
  logic             load_err;
  modport master (output E, F, load, d_in, sat, input y_out, tc, sat_hit, load_err);
  modport slave  (input E, F, load, d_in, sat, output y_out, tc, sat_hit, load_err);
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MOD up/down counter with load, wrap/saturate mode and status pulses.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 10,
  parameter int RST_VAL = 0
) (
  input logic                    clk,
  input logic                    rstn,
  mod_updown_counter_if.slave    bus
);
  // One extra bit so MOD = 2**WIDTH is representable without aliasing.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;
  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d, sat_hit_q, sat_hit_d, load_err_q, load_err_d;
  logic [WIDTH:0]   y_w, d_w, inc_w;
  logic             step, at_lim, over;
  always_comb begin
    y_w        = {1'b0, y_q};
    d_w        = {1'b0, bus.d_in};
    inc_w      = y_w + 1'b1;
    over       = d_w >= MOD_W;
    step       = !bus.load && bus.E;
    at_lim     = bus.F ? (y_w == MAX_W) : (y_q == '0);
    tc_d       = step && at_lim && !bus.sat;
    sat_hit_d  = step && at_lim && bus.sat;
    load_err_d = bus.load && over;
    y_d = bus.load ? (over ? MAX_W[WIDTH-1:0] : bus.d_in) :
          !bus.E   ? y_q :
          at_lim   ? (bus.sat ? y_q : (bus.F ? '0 : MAX_W[WIDTH-1:0])) :
          bus.F    ? inc_w[WIDTH-1:0] : y_q - WIDTH'(1);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q        <= WIDTH'(RST_VAL);
      tc_q       <= 1'b0;
      sat_hit_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      y_q        <= y_d;
      tc_q       <= tc_d;
      sat_hit_q  <= sat_hit_d;
      load_err_q <= load_err_d;
    end
  end
  assign bus.y_out    = y_q;
  assign bus.tc       = tc_q;
  assign bus.sat_hit  = sat_hit_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks of the default counter plus a legacy 2-bit reference run.
module tb_mod_updown_counter;
  logic clk = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  mod_updown_counter_if #(.WIDTH(4)) if_a ();
  mod_updown_counter_if #(.WIDTH(2)) if_b ();
  mod_updown_counter #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut_a (.clk(clk), .rstn(rstn_a), .bus(if_a.slave));
  mod_updown_counter #(.WIDTH(2), .MOD(4), .RST_VAL(0)) dut_b (.clk(clk), .rstn(rstn_b), .bus(if_b.slave));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input int y, input int t, input int sh, input int le);
    chk({tag, ".y"}, int'(if_a.y_out), y);
    chk({tag, ".tc"}, int'(if_a.tc), t);
    chk({tag, ".sat_hit"}, int'(if_a.sat_hit), sh);
    chk({tag, ".load_err"}, int'(if_a.load_err), le);
  endtask
  task automatic drive_a(input logic ld, input int d, input logic e, input logic f, input logic s);
    if_a.load = ld;
    if_a.d_in = 4'(d);
    if_a.E    = e;
    if_a.F    = f;
    if_a.sat  = s;
  endtask
  initial begin
    int m;
    logic e, f;
    drive_a(0, 0, 0, 0, 0);
    if_b.load = 1'b0; if_b.d_in = '0; if_b.E = 1'b0; if_b.F = 1'b0; if_b.sat = 1'b0;
    #1;
    chk_a("reset", 0, 0, 0, 0);
    tick();
    rstn_a = 1'b1;
    drive_a(1, 7, 0, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 0);
    chk_a("load7", 7, 0, 0, 0);
    #2 rstn_a = 1'b0;
    #1 chk_a("async_rst", 0, 0, 0, 0);
    #2 rstn_a = 1'b1;
    drive_a(0, 0, 1, 1, 0);
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_a($sformatf("up%0d", i), (i + 1) % 10, (i == 9) ? 1 : 0, 0, 0);
    end
    drive_a(1, 0, 0, 0, 0);
    tick();
    chk_a("load0", 0, 0, 0, 0);
    drive_a(0, 0, 1, 0, 0);
    tick(); chk_a("dn_wrap", 9, 1, 0, 0);
    tick(); chk_a("dn8", 8, 0, 0, 0);
    tick(); chk_a("dn7", 7, 0, 0, 0);
    drive_a(1, 9, 0, 0, 0);
    tick(); chk_a("load9", 9, 0, 0, 0);
    drive_a(0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("sat%0d", i), 9, 0, 1, 0);
    end
    if_a.F = 1'b0;
    tick(); chk_a("sat_dn", 8, 0, 0, 0);
    drive_a(1, 5, 1, 1, 0);
    tick(); chk_a("ld_prio", 5, 0, 0, 0);
    if_a.d_in = 4'd13;
    tick(); chk_a("ld_clamp", 9, 0, 0, 1);
    if_a.d_in = 4'd0;
    tick(); chk_a("ld_term", 0, 0, 0, 0);
    drive_a(1, 4, 0, 0, 0);
    tick(); chk_a("load4", 4, 0, 0, 0);
    drive_a(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      if_a.F = ~if_a.F;
      tick();
      chk_a($sformatf("hold%0d", i), 4, 0, 0, 0);
    end
    chk("leg_rst.y", int'(if_b.y_out), 0);
    rstn_b = 1'b1;
    m = 0;
    for (int i = 0; i < 200; i++) begin
      e = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if_b.E = e;
      if_b.F = f;
      tick();
      chk("leg.tc", int'(if_b.tc), (e && ((f && m == 3) || (!f && m == 0))) ? 1 : 0);
      if (e) m = f ? (m + 1) % 4 : (m + 3) % 4;
      chk("leg.y", int'(if_b.y_out), m);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the 2-bit enable/direction up/down counter FSM.
- Counts modulo MOD over a WIDTH-bit register. Enable semantics are unchanged: E gates counting, F selects up (1) or down (0).
- Adds synchronous parallel load, a wrap/saturate mode select, and registered status pulses.
- Used as a generic sequencer/position counter in the lab designs; status pulses feed cascade stages and error logging.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- MOD, 10, count modulus; legal range 2..2**WIDTH. Legal count values are 0..MOD-1.
- RST_VAL, 0, value loaded into y_out on reset; must be < MOD.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- E  input  1  count enable; 1 = step this cycle.
- F  input  1  direction; 1 = up, 0 = down. Ignored when E=0.
- load  input  1  synchronous parallel load; has priority over E.
- d_in  input  WIDTH  load value.
- sat  input  1  limit mode; 0 = wrap, 1 = saturate. Sampled every cycle.
- y_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse: wrap occurred on the last edge.
- sat_hit  output  1  pulse: a step was blocked by saturation on the last edge.
- load_err  output  1  pulse: an out-of-range load was clamped on the last edge.

Behaviour:
- Clock and reset: single clock domain, clk only; rstn is asynchronous and active-low.
- Reset (rstn=0, async, immediate): y_out=RST_VAL, tc=0, sat_hit=0, load_err=0. This holds regardless of clk.
- Reset mid-operation: the count is lost and all pulses clear immediately. The first edge after rstn deasserts evaluates normally from RST_VAL.
- All outputs are registered; no combinational path from inputs to outputs. Latency from an input change to the new y_out is one clk edge.
- Pulse outputs (tc, sat_hit, load_err) default to 0 every edge. Each is high for exactly one cycle per qualifying event.
- Priority at each rising edge: load > E > hold.
- load=1, d_in < MOD: y_out <= d_in. E/F/sat ignored. All pulses 0.
- load=1, d_in >= MOD: y_out <= MOD-1 (clamp), load_err <= 1.
- load=0, E=0: y_out holds. F and sat are ignored. All pulses 0.
- load=0, E=1, F=1, y_out < MOD-1: y_out <= y_out+1.
- load=0, E=1, F=1, y_out = MOD-1:
  - sat=0: y_out <= 0, tc <= 1.
  - sat=1: y_out holds, sat_hit <= 1.
- load=0, E=1, F=0, y_out > 0: y_out <= y_out-1.
- load=0, E=1, F=0, y_out = 0:
  - sat=0: y_out <= MOD-1, tc <= 1.
  - sat=1: y_out holds, sat_hit <= 1.
- Arithmetic:
  - Performed at WIDTH+1 bits internally, so MOD = 2**WIDTH wraps correctly with no overflow aliasing.
  - Values >= MOD are unreachable except through invalid parameters, which the implementation does not cover.
- MOD=2**WIDTH, WIDTH=2 behaves identically to the legacy 4-state counter: up 0→1→2→3→0, down 0→3→2→1→0.
- Simultaneous load and terminal condition: the load wins; no tc or sat_hit is generated.
- Changing sat while holding at a limit: takes effect on the next enabled step.

Test Plan:
- Defaults (WIDTH=4, MOD=10, RST_VAL=0): assert rstn=0 mid-count at y_out=7 → y_out=0 immediately, without waiting for clk. Release rstn, E=1, F=1 for 12 edges → y_out 1..9, 0, 1, 2. tc high only in the cycle after the 9→0 edge.
- Down wrap: y_out=0, E=1, F=0, sat=0 → next y_out=9, tc=1 for one cycle. Then 8, 7 with tc=0.
- Saturate: sat=1, y_out=9, E=1, F=1 for 3 edges → y_out stays 9, sat_hit=1 for each of the 3 cycles. Set F=0 → y_out=8, sat_hit=0.
- Load priority and clamp:
  - load=1, d_in=5, E=1, F=1 → y_out=5, no pulses.
  - load=1, d_in=13 → y_out=9, load_err=1 for one cycle.
  - load=1, d_in=0 while y_out=9, E=1, F=1 → y_out=0, tc=0.
- Hold: E=0 with F toggling every cycle for 5 edges at y_out=4 → y_out stays 4, all pulses 0.
- Legacy equivalence (WIDTH=2, MOD=4, RST_VAL=0): random E/F for 200 cycles with load=0, sat=0 → y_out matches the 4-state reference model every cycle. tc is set exactly on the 3→0 and 0→3 transitions.
